alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the 16-bit ALU interface (s/a/b -> y). Accepts commands on a
//  valid/ready port, drives select and operands into the combinational ALU, and
//  captures y into an accumulator. Returns each result on a valid/ready port.
//  Sits between the control/test logic and the ALU instance.
// PARAMETERS
//  WIDTH     16  operand width; ALU result is WIDTH+1 bits
//  OP_W      4   select/opcode width
//  ACC_INIT  0   accumulator value after reset
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous reset, active-low
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept a command
//  cmd_op     in   OP_W     opcode
//  cmd_data   in   WIDTH    immediate operand
//  alu_s      out  OP_W     to ALU select
//  alu_a      out  WIDTH    to ALU a (always the accumulator)
//  alu_b      out  WIDTH    to ALU b (latched immediate)
//  alu_y      in   WIDTH+1  from ALU result
//  rsp_valid  out  1        result present
//  rsp_ready  in   1        consumer takes the result
//  rsp_data   out  WIDTH+1  captured result
//  acc        out  WIDTH    current accumulator
// BEHAVIOUR
//  Opcodes: 0000 AND, 0001 NOR, 0010 ADD, 0011 XOR. These pass to the ALU.
//   1000 LOAD: acc<=cmd_data with no ALU use; rsp_data={0,cmd_data}.
//   1111 CLEAR: acc<=ACC_INIT; rsp_data={0,ACC_INIT}.
//   Any other opcode passes to the ALU unchanged. The ALU then returns 0, and that 0 is captured.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op->alu_s and data->alu_b,
//         then go to EXEC. A LOAD or CLEAR command updates acc here and goes straight to RESP.
//   EXEC: exactly 1 cycle. rsp_data<=alu_y (all WIDTH+1 bits) and acc<=alu_y[WIDTH-1:0].
//         Then go to RESP.
//   RESP: rsp_valid=1. rsp_data and acc are held stable. Leave to IDLE on rsp_ready.
//  cmd_ready=0 in EXEC and RESP. Back-to-back accept is not possible.
//   The next command is accepted in the cycle after the rsp handshake.
//  Latency, accept edge N to rsp_valid: ALU ops N+2, LOAD/CLEAR N+1.
//  alu_s and alu_b hold their last latched values in every state.
//   No glitch on the ALU inputs outside accepts.
//  Carry (bit WIDTH) is exported in rsp_data only. acc truncates to WIDTH bits.
//   ADD wraps: 0xFFFF+0x0001 -> rsp_data=0x10000, acc=0x0000.
//  Reset (rst_n=0 at a rising edge):
//   state=IDLE, acc=ACC_INIT, rsp_data=0, alu_s=0, alu_b=0, rsp_valid=0.
//   cmd_ready=0 while rst_n=0.
//   Reset mid-EXEC or mid-RESP drops the pending result. No response is issued.
//  cmd_valid arriving while busy: no effect, and the command is held off by cmd_ready=0.
//  rsp_ready while rsp_valid=0: ignored.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined: adds output ports flag_c and flag_z (1 bit each).
//   Both are registered in the same cycle as rsp_data and reset to 0.
//   flag_c = captured bit WIDTH.
//   flag_z = (captured bits [WIDTH-1:0] == 0).
//   Both are held until the next capture.
//  ALU_SEQ_FLAGS_EN undefined: the ports and the flag logic are absent. Otherwise identical.
// TESTING
//  1. Reset, then LOAD 0x00F0, then AND 0x0F0F -> rsp 0x00000, acc=0x0000 (flag_z=1).
//  2. LOAD 0xFFFF, then ADD 0x0001 -> alu_s=0010 in EXEC.
//     rsp 0x10000 at N+2, acc=0x0000 (flag_c=1, flag_z=1).
//  3. LOAD 0x1234, then XOR 0xFFFF -> rsp 0x0EDCB. Then NOR 0x0000 -> rsp 0x01234.
//  4. Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_data stable, cmd_ready=0.
//     Second command accepted only after the rsp handshake.
//  5. Opcode 0101 -> ALU returns 0, so rsp 0x00000 and acc=0x0000.
//  6. Drop rst_n in EXEC of ADD -> no rsp_valid, acc=ACC_INIT.
//     Next LOAD 0x0007 responds 0x00007.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//  Bundles the command port, the ALU drive/return lines and the response port
//  of the ALU operation sequencer.
//  Modports:
//   master : the sequencer (accepts commands, drives the ALU, issues responses)
//   slave  : the environment (command source, ALU instance, response sink)
//  Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_data  command handshake, opcode, immediate
//   alu_s/alu_a/alu_b/alu_y               ALU select, operands, WIDTH+1 result
//   rsp_valid/rsp_ready/rsp_data          response handshake and captured result
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OP_W  = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [OP_W-1:0]  alu_s;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH:0]   alu_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, alu_y, rsp_ready,
    output cmd_ready, alu_s, alu_a, alu_b, rsp_valid, rsp_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, alu_y, rsp_ready,
    input  cmd_ready, alu_s, alu_a, alu_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//  Initiator side of the combinational ALU (s/a/b -> y). Accepts one command at a
//  time, drives select and operands into the ALU, captures the result into an
//  accumulator and returns it on a valid/ready response port.
//  Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      alu_op_sequencer_if.master (command, ALU and response signals)
//   acc      current accumulator (also driven onto bus.alu_a)
//  Optional build macro ALU_SEQ_FLAGS_EN adds outputs flag_c (captured carry)
//  and flag_z (captured low WIDTH bits are zero), registered with rsp_data.
module alu_op_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      OP_W     = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.master bus,
  output logic [WIDTH-1:0]   acc
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic               flag_c,
  output logic               flag_z
`endif
);

  localparam logic [OP_W-1:0] OpLoad  = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OpClear = OP_W'(4'b1111);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   rsp_q, rsp_d;
  logic [OP_W-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  // cap_en marks the cycle in which a result (ALU or immediate) is captured.
  logic             cap_en;
  logic [WIDTH:0]   cap_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= ACC_INIT;
      rsp_q   <= '0;
      sel_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      sel_q   <= sel_d;
      opb_q   <= opb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    opb_d   = opb_q;
    cap_en  = 1'b0;
    cap_val = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          sel_d = bus.cmd_op;
          opb_d = bus.cmd_data;
          if (bus.cmd_op == OpLoad) begin
            cap_en  = 1'b1;
            cap_val = {1'b0, bus.cmd_data};
            state_d = StResp;
          end else if (bus.cmd_op == OpClear) begin
            cap_en  = 1'b1;
            cap_val = {1'b0, ACC_INIT};
            state_d = StResp;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        cap_en  = 1'b1;
        cap_val = bus.alu_y;
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    acc_d = cap_en ? cap_val[WIDTH-1:0] : acc_q;
    rsp_d = cap_en ? cap_val : rsp_q;
  end

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign bus.cmd_ready = (state_q == StIdle) && rst_n;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_q;
  assign bus.alu_s     = sel_q;
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = opb_q;
  assign acc           = acc_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_c_q, flag_z_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (cap_en) begin
      flag_c_q <= cap_val[WIDTH];
      flag_z_q <= (cap_val[WIDTH-1:0] == '0);
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//  Drives directed and random commands into alu_op_sequencer, supplies a
//  behavioural ALU on the ALU side, and compares responses, accumulator,
//  latency and handshake behaviour against a reference accumulator model.
module tb_alu_op_sequencer;

  localparam int unsigned      W        = 16;
  localparam int unsigned      OW       = 4;
  localparam logic [W-1:0]     ACC_INIT = 16'h5A5A;

  localparam logic [3:0] OpAnd = 4'b0000, OpNor = 4'b0001, OpAdd = 4'b0010,
                         OpXor = 4'b0011, OpLoad = 4'b1000, OpClear = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] acc;
`ifdef ALU_SEQ_FLAGS_EN
  logic flag_c, flag_z;
`endif

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [W-1:0] m_acc;
  logic [W:0]   m_rsp;
  logic         m_fc, m_fz;

  alu_op_sequencer_if #(.WIDTH(W), .OP_W(OW)) bus ();

  alu_op_sequencer #(.WIDTH(W), .OP_W(OW), .ACC_INIT(ACC_INIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .acc    (acc)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_c (flag_c),
    .flag_z (flag_z)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU instance on the far side of the sequencer.
  logic [W:0] alu_y_m;
  always_comb begin
    alu_y_m = '0;
    case (bus.alu_s)
      OpAnd:   alu_y_m = {1'b0, bus.alu_a & bus.alu_b};
      OpNor:   alu_y_m = {1'b0, ~(bus.alu_a | bus.alu_b)};
      OpAdd:   alu_y_m = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OpXor:   alu_y_m = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_y_m = '0;
    endcase
  end
  assign bus.alu_y = alu_y_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected result of one command given the accumulator before it.
  function automatic logic [W:0] ref_result(input logic [3:0] op, input logic [W-1:0] d,
                                            input logic [W-1:0] a);
    int unsigned sum;
    case (op)
      OpAnd:   return {1'b0, a & d};
      OpNor:   return {1'b0, ~(a | d)};
      OpAdd:   begin sum = int'(a) + int'(d); return sum[W:0]; end
      OpXor:   return {1'b0, a ^ d};
      OpLoad:  return {1'b0, d};
      OpClear: return {1'b0, ACC_INIT};
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = ACC_INIT;
    m_rsp = '0;
    m_fc  = 1'b0;
    m_fz  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(m_rsp));
    check_eq({tag, "_acc"}, 32'(acc), 32'(m_acc));
`ifdef ALU_SEQ_FLAGS_EN
    check_eq({tag, "_flag_c"}, 32'(flag_c), 32'(m_fc));
    check_eq({tag, "_flag_z"}, 32'(flag_z), 32'(m_fz));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_alu_s", 32'(bus.alu_s), 32'd0);
    check_eq("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  // Issue one command at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] d, input int stall,
                         input bit hold_next);
    logic [W:0] exp;
    bit short_lat;
    short_lat = (op == OpLoad) || (op == OpClear);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = hold_next;
    bus.cmd_op    = 4'(op + 4'd3);
    bus.cmd_data  = ~d;
    check_eq("alu_s_latched", 32'(bus.alu_s), 32'(op));
    check_eq("alu_b_latched", 32'(bus.alu_b), 32'(d));
    check_eq("busy_ready", 32'(bus.cmd_ready), 32'd0);
    exp   = ref_result(op, d, m_acc);
    m_rsp = exp;
    m_acc = exp[W-1:0];
    m_fc  = exp[W];
    m_fz  = (exp[W-1:0] == '0);
    if (!short_lat) begin
      check_eq("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check_eq("rsp_valid_lat", 32'(bus.rsp_valid), 32'd1);
    check_outputs("rsp");
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("stall_ready", 32'(bus.cmd_ready), 32'd0);
      check_outputs("stall");
      check_eq("stall_alu_s", 32'(bus.alu_s), 32'(op));
      check_eq("stall_alu_b", 32'(bus.alu_b), 32'(d));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check_eq("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_hs_ready", 32'(bus.cmd_ready), 32'd1);
    check_outputs("post_hs");
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] d;
    int r;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // 1
    do_reset();
    run_cmd(OpLoad, 16'h00F0, 0, 1'b0);
    run_cmd(OpAnd, 16'h0F0F, 1, 1'b0);
    // 2
    run_cmd(OpLoad, 16'hFFFF, 0, 1'b0);
    run_cmd(OpAdd, 16'h0001, 0, 1'b0);
    // 3
    run_cmd(OpLoad, 16'h1234, 0, 1'b0);
    run_cmd(OpXor, 16'hFFFF, 0, 1'b0);
    run_cmd(OpNor, 16'h0000, 0, 1'b0);
    // 4: stalled response with a competing command held on the port
    run_cmd(OpAdd, 16'h0101, 5, 1'b1);
    run_cmd(OpLoad, 16'hBEEF, 5, 1'b1);
    // 5
    run_cmd(4'b0101, 16'h7777, 0, 1'b0);
    run_cmd(OpClear, 16'h1111, 0, 1'b0);

    // 6: reset during EXEC of an ADD drops the result
    run_cmd(OpLoad, 16'h0003, 0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OpAdd;
    bus.cmd_data  = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_eq("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("midrst_ready", 32'(bus.cmd_ready), 32'd0);
    check_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("postrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    run_cmd(OpLoad, 16'h0007, 0, 1'b0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: op = OpAnd;
        1: op = OpNor;
        2, 6: op = OpAdd;
        3: op = OpXor;
        4: op = OpLoad;
        5: op = OpClear;
        default: op = 4'($urandom_range(0, 15));
      endcase
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        // rsp_ready with nothing pending must be ignored
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("idle_rsp_ready_ignored", 32'(bus.rsp_valid), 32'd0);
        check_outputs("idle");
      end
      run_cmd(op, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
